// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - fetch/write-back/hazard inputs and ID/EX bundle of the decode stage
//
// Purpose: groups every decode-stage signal except clk/rst.
// master : upstream side (fetch, WB, hazard unit, status) driving decode inputs.
// slave  : the id_stage itself, driving the hazard indices and the ID/EX bundle.
// Inputs  : pc_in, instruction, hazard, flush, status, wb_en_in, wb_dest, wb_value
// Outputs : src1, src2, two_src (combinational); pc_out, val_rn, val_rm, imm,
//           shift_operand, signed_imm_24, dest, exe_cmd, mem_r_en, mem_w_en,
//           wb_en, b, s (registered)
interface id_stage_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pc_in;
    logic [31:0]      instruction;
    logic             hazard;
    logic             flush;
    logic [3:0]       status;
    logic             wb_en_in;
    logic [3:0]       wb_dest;
    logic [WIDTH-1:0] wb_value;

    logic [3:0]       src1;
    logic [3:0]       src2;
    logic             two_src;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] val_rn;
    logic [WIDTH-1:0] val_rm;
    logic             imm;
    logic [11:0]      shift_operand;
    logic [23:0]      signed_imm_24;
    logic [3:0]       dest;
    logic [3:0]       exe_cmd;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             wb_en;
    logic             b;
    logic             s;

    modport master (
        output pc_in, instruction, hazard, flush, status, wb_en_in, wb_dest, wb_value,
        input  src1, src2, two_src, pc_out, val_rn, val_rm, imm, shift_operand,
               signed_imm_24, dest, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s
    );

    modport slave (
        input  pc_in, instruction, hazard, flush, status, wb_en_in, wb_dest, wb_value,
        output src1, src2, two_src, pc_out, val_rn, val_rm, imm, shift_operand,
               signed_imm_24, dest, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s
    );
endinterface

// File: rtl/id_stage.sv
// rtl/id_stage.sv - ARM pipeline decode stage with register file and ID/EX register
//
// Purpose: decodes the fetched instruction, reads R0..R14 (R15 reads as pc_in),
// evaluates the condition against NZCV and registers the ID/EX bundle.
// Ports: clk, rst (synchronous, active-low), io_bus (id_stage_if.slave).
module id_stage #(
    parameter int NUM_REGS = 15,
    parameter int WIDTH    = 32
) (
    input  logic        clk,
    input  logic        rst,
    id_stage_if.slave   io_bus
);
    logic [WIDTH-1:0] r_regs [NUM_REGS];

    logic [WIDTH-1:0] r_pc_out, r_val_rn, r_val_rm;
    logic             r_imm;
    logic [11:0]      r_shift_operand;
    logic [23:0]      r_signed_imm_24;
    logic [3:0]       r_dest;
    logic [8:0]       r_ctl;

    logic [3:0]       w_cond, w_src1, w_src2;
    logic [1:0]       w_mode;
    logic             w_n, w_z, w_c, w_v;
    logic             w_cond_pass;
    logic [3:0]       w_exe_cmd;
    logic             w_mem_r_en, w_mem_w_en, w_wb_en, w_b, w_s;
    logic [WIDTH-1:0] w_val_rn, w_val_rm;

    assign w_cond = io_bus.instruction[31:28];
    assign w_mode = io_bus.instruction[27:26];
    assign {w_n, w_z, w_c, w_v} = io_bus.status;

    always_comb begin
        w_cond_pass = 1'b0;
        case (w_cond)
            4'b0000: w_cond_pass = w_z;
            4'b0001: w_cond_pass = ~w_z;
            4'b0010: w_cond_pass = w_c;
            4'b0011: w_cond_pass = ~w_c;
            4'b0100: w_cond_pass = w_n;
            4'b0101: w_cond_pass = ~w_n;
            4'b0110: w_cond_pass = w_v;
            4'b0111: w_cond_pass = ~w_v;
            4'b1000: w_cond_pass = w_c & ~w_z;
            4'b1001: w_cond_pass = ~w_c | w_z;
            4'b1010: w_cond_pass = (w_n == w_v);
            4'b1011: w_cond_pass = (w_n != w_v);
            4'b1100: w_cond_pass = ~w_z & (w_n == w_v);
            4'b1101: w_cond_pass = w_z | (w_n != w_v);
            4'b1110: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        w_exe_cmd  = 4'b0000;
        w_mem_r_en = 1'b0;
        w_mem_w_en = 1'b0;
        w_wb_en    = 1'b0;
        w_b        = 1'b0;
        w_s        = 1'b0;
        case (w_mode)
            2'b00: begin
                w_wb_en = 1'b1;
                w_s     = io_bus.instruction[20];
                case (io_bus.instruction[24:21])
                    4'b1101: w_exe_cmd = 4'b0001;
                    4'b1111: w_exe_cmd = 4'b1001;
                    4'b0100: w_exe_cmd = 4'b0010;
                    4'b0101: w_exe_cmd = 4'b0011;
                    4'b0010: w_exe_cmd = 4'b0100;
                    4'b0110: w_exe_cmd = 4'b0101;
                    4'b0000: w_exe_cmd = 4'b0110;
                    4'b1100: w_exe_cmd = 4'b0111;
                    4'b0001: w_exe_cmd = 4'b1000;
                    4'b1010: begin w_exe_cmd = 4'b0100; w_wb_en = 1'b0; end
                    4'b1000: begin w_exe_cmd = 4'b0110; w_wb_en = 1'b0; end
                    default: begin w_wb_en = 1'b0; w_s = 1'b0; end
                endcase
            end
            2'b01: begin
                w_exe_cmd = 4'b0010;
                if (io_bus.instruction[20]) begin
                    w_mem_r_en = 1'b1;
                    w_wb_en    = 1'b1;
                end else begin
                    w_mem_w_en = 1'b1;
                end
            end
            2'b10: w_b = 1'b1;
            default: ;
        endcase
    end

    // A store reads its data register Rd through the second read port.
    assign w_src1 = io_bus.instruction[19:16];
    assign w_src2 = w_mem_w_en ? io_bus.instruction[15:12] : io_bus.instruction[3:0];

    assign io_bus.src1    = w_src1;
    assign io_bus.src2    = w_src2;
    assign io_bus.two_src = ~io_bus.instruction[25] | w_mem_w_en;

    // Read ports: R15 is the pc; a same-cycle write-back is bypassed so the
    // decoded value never lags the register file by one cycle.
    always_comb begin
        if (w_src1 == 4'hF)
            w_val_rn = io_bus.pc_in;
        else if (io_bus.wb_en_in && io_bus.wb_dest == w_src1)
            w_val_rn = io_bus.wb_value;
        else
            w_val_rn = r_regs[w_src1];
    end

    always_comb begin
        if (w_src2 == 4'hF)
            w_val_rm = io_bus.pc_in;
        else if (io_bus.wb_en_in && io_bus.wb_dest == w_src2)
            w_val_rm = io_bus.wb_value;
        else
            w_val_rm = r_regs[w_src2];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_REGS; k++)
                r_regs[k] <= '0;
        end else if (io_bus.wb_en_in && io_bus.wb_dest != 4'hF) begin
            r_regs[io_bus.wb_dest] <= io_bus.wb_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || io_bus.flush) begin
            r_pc_out        <= '0;
            r_val_rn        <= '0;
            r_val_rm        <= '0;
            r_imm           <= 1'b0;
            r_shift_operand <= '0;
            r_signed_imm_24 <= '0;
            r_dest          <= '0;
            r_ctl           <= '0;
        end else begin
            r_pc_out        <= io_bus.pc_in;
            r_val_rn        <= w_val_rn;
            r_val_rm        <= w_val_rm;
            r_imm           <= io_bus.instruction[25];
            r_shift_operand <= io_bus.instruction[11:0];
            r_signed_imm_24 <= io_bus.instruction[23:0];
            r_dest          <= io_bus.instruction[15:12];
            // Bubble or failed condition: data still flows, control is squashed.
            if (io_bus.hazard || !w_cond_pass)
                r_ctl <= '0;
            else
                r_ctl <= {w_exe_cmd, w_mem_r_en, w_mem_w_en, w_wb_en, w_b, w_s};
        end
    end

    assign io_bus.pc_out        = r_pc_out;
    assign io_bus.val_rn        = r_val_rn;
    assign io_bus.val_rm        = r_val_rm;
    assign io_bus.imm           = r_imm;
    assign io_bus.shift_operand = r_shift_operand;
    assign io_bus.signed_imm_24 = r_signed_imm_24;
    assign io_bus.dest          = r_dest;
    assign {io_bus.exe_cmd, io_bus.mem_r_en, io_bus.mem_w_en,
            io_bus.wb_en, io_bus.b, io_bus.s} = r_ctl;
endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vecs = 0;
    int   errs = 0;

    id_stage_if #(.WIDTH(32)) bus ();

    id_stage #(.NUM_REGS(15), .WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    logic [8:0]   ctl;
    logic [151:0] all_out;
    assign ctl = {bus.exe_cmd, bus.mem_r_en, bus.mem_w_en, bus.wb_en, bus.b, bus.s};
    assign all_out = {bus.pc_out, bus.val_rn, bus.val_rm, bus.imm, bus.shift_operand,
                      bus.signed_imm_24, bus.dest, ctl};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.instruction = 32'hE0831003;
        bus.pc_in = 32'h44;
        bus.wb_en_in = 1'b1; bus.wb_dest = 4'd3; bus.wb_value = 32'h99;
        tick();
        vecs++;
        if (all_out !== '0) begin $display("FAIL reset_active: got %h want 0", all_out); errs++; end
        rst = 1'b1;
        bus.instruction = 32'h0; bus.pc_in = 32'h0; bus.wb_en_in = 1'b0;
        tick();
        vecs++;
        if (all_out !== '0) begin $display("FAIL reset_release: got %h want 0", all_out); errs++; end
        for (int i = 0; i < 15; i++) begin
            bus.instruction = 32'hE1A00000 | i;
            tick();
            vecs++;
            if (bus.val_rm !== 32'h0) begin
                $display("FAIL reset_reg R%0d: got %h want 0", i, bus.val_rm); errs++;
            end
        end
    endtask

    task automatic test_bypass;
        bus.wb_en_in = 1'b1; bus.wb_dest = 4'd3; bus.wb_value = 32'h1234;
        bus.instruction = 32'hE0831003;
        tick();
        bus.wb_en_in = 1'b0;
        vecs++;
        if (bus.val_rn !== 32'h1234) begin $display("FAIL bypass_rn: got %h want 1234", bus.val_rn); errs++; end
        vecs++;
        if (bus.val_rm !== 32'h1234) begin $display("FAIL bypass_rm: got %h want 1234", bus.val_rm); errs++; end
        vecs++;
        if (ctl !== 9'b0010_00100) begin $display("FAIL bypass_ctl: got %b want 001000100", ctl); errs++; end
        vecs++;
        if (bus.dest !== 4'd1) begin $display("FAIL bypass_dest: got %h want 1", bus.dest); errs++; end
        tick();
        vecs++;
        if (bus.val_rn !== 32'h1234) begin $display("FAIL stored_r3: got %h want 1234", bus.val_rn); errs++; end
    endtask

    task automatic test_opcodes;
        logic [3:0] opc [12] = '{4'hD, 4'hF, 4'h4, 4'h5, 4'h2, 4'h6, 4'h0, 4'hC, 4'h1, 4'hA, 4'h8, 4'h3};
        logic [8:0] exp [12] = '{9'b0001_00101, 9'b1001_00101, 9'b0010_00101, 9'b0011_00101,
                                 9'b0100_00101, 9'b0101_00101, 9'b0110_00101, 9'b0111_00101,
                                 9'b1000_00101, 9'b0100_00001, 9'b0110_00001, 9'b0000_00000};
        for (int i = 0; i < 12; i++) begin
            bus.instruction = 32'hE0100000 | (32'(opc[i]) << 21);
            tick();
            vecs++;
            if (ctl !== exp[i]) begin
                $display("FAIL opcode_%h: got %b want %b", opc[i], ctl, exp[i]); errs++;
            end
        end
    endtask

    task automatic test_conditions;
        logic [3:0] cnd [12] = '{4'hA, 4'hB, 4'h8, 4'h8, 4'h9, 4'hC, 4'hC, 4'hD, 4'hF, 4'h1, 4'h3, 4'h6};
        logic [3:0] st  [12] = '{4'b1001, 4'b1001, 4'b0010, 4'b0110, 4'b0110, 4'b0000,
                                 4'b0100, 4'b1000, 4'b1111, 4'b0000, 4'b0010, 4'b0001};
        logic       ok  [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bus.instruction = 32'h03A0000A;
        bus.status = 4'b0100;
        tick();
        vecs++;
        if (ctl !== 9'b0001_00100) begin $display("FAIL moveq_pass: got %b want 000100100", ctl); errs++; end
        bus.status = 4'b0000;
        tick();
        vecs++;
        if (ctl !== 9'b0) begin $display("FAIL moveq_fail_ctl: got %b want 0", ctl); errs++; end
        vecs++;
        if (bus.shift_operand !== 12'h00A) begin $display("FAIL moveq_fail_shop: got %h want 00a", bus.shift_operand); errs++; end
        vecs++;
        if (bus.imm !== 1'b1) begin $display("FAIL moveq_fail_imm: got %b want 1", bus.imm); errs++; end
        for (int i = 0; i < 12; i++) begin
            bus.instruction = {cnd[i], 28'h3A0000A};
            bus.status = st[i];
            tick();
            vecs++;
            if (ctl !== (ok[i] ? 9'b0001_00100 : 9'b0)) begin
                $display("FAIL cond_%h_nzcv_%b: got %b want pass=%b", cnd[i], st[i], ctl, ok[i]); errs++;
            end
        end
        bus.status = 4'b0000;
    endtask

    task automatic test_memory;
        bus.instruction = 32'h0;
        bus.wb_en_in = 1'b1; bus.wb_dest = 4'd1; bus.wb_value = 32'h100;
        tick();
        bus.wb_dest = 4'd2; bus.wb_value = 32'h55;
        tick();
        bus.wb_en_in = 1'b0;
        bus.instruction = 32'hE5812004;
        #1;
        vecs++;
        if (bus.src2 !== 4'd2) begin $display("FAIL str_src2: got %h want 2", bus.src2); errs++; end
        vecs++;
        if (bus.two_src !== 1'b1) begin $display("FAIL str_two_src: got %b want 1", bus.two_src); errs++; end
        vecs++;
        if (bus.src1 !== 4'd1) begin $display("FAIL str_src1: got %h want 1", bus.src1); errs++; end
        tick();
        vecs++;
        if (ctl !== 9'b0010_01000) begin $display("FAIL str_ctl: got %b want 001001000", ctl); errs++; end
        vecs++;
        if (bus.val_rn !== 32'h100) begin $display("FAIL str_rn: got %h want 100", bus.val_rn); errs++; end
        vecs++;
        if (bus.val_rm !== 32'h55) begin $display("FAIL str_rd_value: got %h want 55", bus.val_rm); errs++; end
        bus.instruction = 32'hE5912004;
        #1;
        vecs++;
        if (bus.src2 !== 4'd4) begin $display("FAIL ldr_src2: got %h want 4", bus.src2); errs++; end
        tick();
        vecs++;
        if (ctl !== 9'b0010_10100) begin $display("FAIL ldr_ctl: got %b want 001010100", ctl); errs++; end
        vecs++;
        if (bus.dest !== 4'd2) begin $display("FAIL ldr_dest: got %h want 2", bus.dest); errs++; end
    endtask

    task automatic test_hazard_flush;
        bus.hazard = 1'b1;
        bus.instruction = 32'hE0831003;
        tick();
        vecs++;
        if (ctl !== 9'b0) begin $display("FAIL hazard_ctl: got %b want 0", ctl); errs++; end
        vecs++;
        if (bus.val_rn !== 32'h1234) begin $display("FAIL hazard_rn: got %h want 1234", bus.val_rn); errs++; end
        vecs++;
        if (bus.dest !== 4'd1) begin $display("FAIL hazard_dest: got %h want 1", bus.dest); errs++; end
        bus.flush = 1'b1;
        tick();
        vecs++;
        if (all_out !== '0) begin $display("FAIL flush_all: got %h want 0", all_out); errs++; end
        bus.flush = 1'b0; bus.hazard = 1'b0;
        bus.instruction = 32'hEA000010; bus.pc_in = 32'h40;
        tick();
        vecs++;
        if (ctl !== 9'b0000_00010) begin $display("FAIL branch_ctl: got %b want 000000010", ctl); errs++; end
        vecs++;
        if (bus.signed_imm_24 !== 24'h000010) begin $display("FAIL branch_imm: got %h want 000010", bus.signed_imm_24); errs++; end
        vecs++;
        if (bus.pc_out !== 32'h40) begin $display("FAIL branch_pc: got %h want 40", bus.pc_out); errs++; end
    endtask

    task automatic test_r15_write;
        bus.wb_en_in = 1'b1; bus.wb_dest = 4'hF; bus.wb_value = 32'hDEAD;
        bus.pc_in = 32'h80;
        bus.instruction = 32'hE08F100F;
        tick();
        vecs++;
        if (bus.val_rn !== 32'h80) begin $display("FAIL r15_rn: got %h want 80", bus.val_rn); errs++; end
        vecs++;
        if (bus.val_rm !== 32'h80) begin $display("FAIL r15_rm: got %h want 80", bus.val_rm); errs++; end
        bus.wb_en_in = 1'b0;
        bus.instruction = 32'hE1A0000E;
        tick();
        vecs++;
        if (bus.val_rm !== 32'h0) begin $display("FAIL r15_r14_intact: got %h want 0", bus.val_rm); errs++; end
        bus.instruction = 32'hE1A00003;
        tick();
        vecs++;
        if (bus.val_rm !== 32'h1234) begin $display("FAIL r15_r3_intact: got %h want 1234", bus.val_rm); errs++; end
    endtask

    task automatic test_reset_midstream;
        bus.instruction = 32'hE0831003;
        bus.wb_en_in = 1'b1; bus.wb_dest = 4'd3; bus.wb_value = 32'hBEEF;
        rst = 1'b0;
        tick();
        vecs++;
        if (all_out !== '0) begin $display("FAIL midreset_all: got %h want 0", all_out); errs++; end
        rst = 1'b1; bus.wb_en_in = 1'b0;
        tick();
        vecs++;
        if (bus.val_rn !== 32'h0) begin $display("FAIL midreset_r3: got %h want 0", bus.val_rn); errs++; end
        vecs++;
        if (ctl !== 9'b0010_00100) begin $display("FAIL midreset_ctl: got %b want 001000100", ctl); errs++; end
    endtask

    initial begin
        bus.pc_in = '0; bus.instruction = '0; bus.hazard = 1'b0; bus.flush = 1'b0;
        bus.status = 4'b0; bus.wb_en_in = 1'b0; bus.wb_dest = 4'd0; bus.wb_value = '0;
        test_reset();
        test_bypass();
        test_opcodes();
        test_conditions();
        test_memory();
        test_hazard_flush();
        test_r15_write();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
